// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 timing, totals and helpers shared by the VGA window controller.
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic hit;
    logic fs;
    logic ls;
  } flags_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r < 1 ? 1 : r;
  endfunction

  function automatic logic sync_level(input logic act, input logic pol);
    return act ? pol : ~pol;
  endfunction
endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: free-running h/v counters with raw sync, active-area and line/frame flags.
module vga_timing_counter import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW       = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_hs_act,
  output logic          o_vs_act,
  output logic          o_active,
  output logic          o_line_start,
  output logic          o_line_end,
  output logic          o_frame_start
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_h_end;
  logic          w_v_end;
  assign w_h_end = r_h == HW'(HT - 1);
  assign w_v_end = r_v == VW'(VT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_end ? '0 : r_h + 1'b1;
      if (w_h_end) r_v <= w_v_end ? '0 : r_v + 1'b1;
    end
  assign o_h_cnt       = r_h;
  assign o_v_cnt       = r_v;
  assign o_hs_act      = r_h >= HW'(H_ACTIVE + H_FP) && r_h <= HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  assign o_vs_act      = r_v >= VW'(V_ACTIVE + V_FP) && r_v <= VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  assign o_active      = r_h < HW'(H_ACTIVE) && r_v < VW'(V_ACTIVE);
  assign o_line_start  = r_h == '0;
  assign o_line_end    = w_h_end;
  assign o_frame_start = r_h == '0 && r_v == '0;
endmodule

// File: rtl/vga_window_ctrl.sv
// vga_window_ctrl: VGA timing plus a replicated framebuffer window, with sync/DE/colour
// realigned to the framebuffer read latency.
module vga_window_ctrl import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 1,
  parameter int WIN_X0   = 240,
  parameter int WIN_Y0   = 180,
  parameter int WIN_W    = 160,
  parameter int WIN_H    = 120,
  parameter int SCALE_SH = 0,
  parameter int ADDR_W   = 15,
  parameter int MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     r_in,
  input  logic [CW-1:0]     g_in,
  input  logic [CW-1:0]     b_in,
  output logic [ADDR_W-1:0] addr,
  output logic              h_sync,
  output logic              v_sync,
  output logic [CW-1:0]     r_out,
  output logic [CW-1:0]     g_out,
  output logic [CW-1:0]     b_out,
  output logic              de,
  output logic              frame_start,
  output logic              line_start
);
  localparam int HW = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int X1 = WIN_X0 + (WIN_W << SCALE_SH);
  localparam int Y1 = WIN_Y0 + (WIN_H << SCALE_SH);
  localparam int SW = SCALE_SH > 0 ? SCALE_SH : 1;
  localparam logic [SW-1:0] SMAX = SW'((1 << SCALE_SH) - 1);
  localparam int D = MEM_LAT + 1;
  localparam flags_t FLUSH = {~SYNC_POL, ~SYNC_POL, 4'b0};

  if ((64'd1 << ADDR_W) < 64'(WIN_W * WIN_H)) begin : g_bad_addr_w
    $error("ADDR_W too small for WIN_W*WIN_H");
  end
  if (MEM_LAT < 1) begin : g_bad_lat
    $error("MEM_LAT must be at least 1");
  end

  logic [HW-1:0]     w_h;
  logic [VW-1:0]     w_v;
  logic              w_hs_act, w_vs_act, w_active, w_line, w_line_end, w_frame;
  logic [31:0]       w_x, w_y;
  logic              w_vin, w_hit;
  flags_t            w_flags;
  flags_t [D-1:0]    r_pipe;
  logic [ADDR_W-1:0] r_addr, r_row, r_col;
  logic [SW-1:0]     r_sx, r_sy;
  logic [CW-1:0]     r_r, r_g, r_b;

  vga_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_tc (
    .clk(clk), .rst(rst), .o_h_cnt(w_h), .o_v_cnt(w_v),
    .o_hs_act(w_hs_act), .o_vs_act(w_vs_act), .o_active(w_active),
    .o_line_start(w_line), .o_line_end(w_line_end), .o_frame_start(w_frame)
  );

  // Window is clipped to the active area so an off-screen window never drives colour.
  assign w_x     = 32'(w_h);
  assign w_y     = 32'(w_v);
  assign w_vin   = w_y >= WIN_Y0 && w_y < Y1 && w_y < V_ACTIVE;
  assign w_hit   = w_vin && w_x >= WIN_X0 && w_x < X1 && w_x < H_ACTIVE;
  assign w_flags = {sync_level(w_hs_act, SYNC_POL), sync_level(w_vs_act, SYNC_POL),
                    w_active, w_hit, w_frame, w_line};

  // Column/row replication counters step the source address without a multiplier.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_addr <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_sx   <= '0;
      r_sy   <= '0;
    end else begin
      r_addr <= w_hit ? r_row + r_col : '0;
      r_sx   <= w_hit && r_sx != SMAX ? r_sx + 1'b1 : '0;
      r_col  <= !w_hit ? '0 : r_sx == SMAX ? r_col + 1'b1 : r_col;
      if (!w_vin) begin
        r_sy  <= '0;
        r_row <= '0;
      end else if (w_line_end) begin
        r_sy  <= r_sy == SMAX ? '0 : r_sy + 1'b1;
        if (r_sy == SMAX) r_row <= r_row + ADDR_W'(WIN_W);
      end
    end

  // Colour is captured on the edge that the delayed flags reach the outputs.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pipe <= {D{FLUSH}};
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
    end else begin
      r_pipe <= {r_pipe[D-2:0], w_flags};
      r_r    <= r_pipe[D-2].hit ? r_in : '0;
      r_g    <= r_pipe[D-2].hit ? g_in : '0;
      r_b    <= r_pipe[D-2].hit ? b_in : '0;
    end

  assign addr        = r_addr;
  assign h_sync      = r_pipe[D-1].hs;
  assign v_sync      = r_pipe[D-1].vs;
  assign de          = r_pipe[D-1].de;
  assign frame_start = r_pipe[D-1].fs;
  assign line_start  = r_pipe[D-1].ls;
  assign r_out       = r_r;
  assign g_out       = r_g;
  assign b_out       = r_b;
endmodule

// File: tb/tb_vga_window_ctrl.sv
// tb_vga_window_ctrl: random framebuffer contents and a random mid-window reset, checked every
// clock against a screen-position model through an expectation queue.
module tb_vga_window_ctrl;
  localparam int HA = 40, HFP = 4, HS = 6, HBP = 6;
  localparam int VA = 30, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int CW = 2, X0 = 28, Y0 = 10, W = 8, H = 8, S = 1, AW = 6, LAT = 3;
  localparam bit POL = 1'b0;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            hs;
    logic            vs;
    logic            de;
    logic            fs;
    logic            ls;
    logic [3*CW-1:0] rgb;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] r_in, g_in, b_in, r_out, g_out, b_out;
  logic [AW-1:0] addr;
  logic h_sync, v_sync, de, frame_start, line_start;
  logic [3*CW-1:0] mem [2**AW];
  logic [AW-1:0] a_q [LAT-1];
  int k;
  int vectors = 0;
  int miscompares = 0;
  obs_t exp_q [$];

  vga_window_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(POL), .CW(CW), .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(W), .WIN_H(H),
    .SCALE_SH(S), .ADDR_W(AW), .MEM_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in), .addr(addr),
    .h_sync(h_sync), .v_sync(v_sync), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .de(de), .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clk = ~clk;

  // Framebuffer model: data is sampled by the DUT MEM_LAT edges after the address edge.
  always @(posedge clk) begin
    a_q[0] <= addr;
    for (int i = 1; i < LAT - 1; i++) a_q[i] <= a_q[i-1];
  end
  assign {r_in, g_in, b_in} = mem[a_q[LAT-2]];

  always @(posedge clk or posedge rst) k <= rst ? 0 : k + 1;

  function automatic bit in_win(input int n);
    int h, v;
    h = n % HT;
    v = (n / HT) % VT;
    return h >= X0 && h < X0 + (W << S) && h < HA && v >= Y0 && v < Y0 + (H << S) && v < VA;
  endfunction

  function automatic int src(input int n);
    int h, v;
    h = n % HT;
    v = (n / HT) % VT;
    return in_win(n) ? ((v - Y0) >> S) * W + ((h - X0) >> S) : 0;
  endfunction

  function automatic obs_t model(input int kk);
    obs_t e;
    int n, h, v;
    e = '0;
    e.addr = kk >= 1 ? AW'(src(kk - 1)) : '0;
    e.hs = ~POL;
    e.vs = ~POL;
    if (kk >= LAT + 1) begin
      n = kk - LAT - 1;
      h = n % HT;
      v = (n / HT) % VT;
      e.hs = (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
      e.vs = (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
      e.de = h < HA && v < VA;
      e.fs = h == 0 && v == 0;
      e.ls = h == 0;
      e.rgb = in_win(n) ? mem[src(n)] : '0;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    exp_q.push_back(model(k));
  end

  always @(negedge clk) begin
    obs_t got, e;
    got = {addr, h_sync, v_sync, de, frame_start, line_start, r_out, g_out, b_out};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL queue_empty k=%0d got=%h required=an expectation", k, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e)  begin
        miscompares++;
        $display("FAIL pixel k=%0d got addr=%0d hs=%b vs=%b de=%b fs=%b ls=%b rgb=%h required addr=%0d hs=%b vs=%b de=%b fs=%b ls=%b rgb=%h",
                 k, got.addr, got.hs, got.vs, got.de, got.fs, got.ls, got.rgb,
                 e.addr, e.hs, e.vs, e.de, e.fs, e.ls, e.rgb);
      end
    end
  end

  initial begin
    int tgt;
    foreach (mem[i]) mem[i] = (3*CW)'($urandom);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2 * FRAME + 300) @(posedge clk);
    tgt = (k / FRAME + 1) * FRAME + (Y0 + 5) * HT + int'($urandom_range(0, HT - 1));
    while (k < tgt) @(posedge clk);
    #3 rst = 1'b1;
    exp_q.delete();
    exp_q.push_back(model(0));
    repeat (int'($urandom_range(1, 4))) @(negedge clk);
    #1 rst = 1'b0;
    repeat (FRAME + 200) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
